// File: rtl/chip_spreader.sv
// Symbol-to-chip spreader: fetches 4-bit symbols serially from an upstream
// FIFO and emits a 32-chip sequence per symbol at the chip-tick rate.
module chip_spreader #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int LEN_WIDTH      = 8
) (
  input  logic                 inClock,
  input  logic                 inReset,
  input  logic                 inStart,
  input  logic [LEN_WIDTH-1:0] inLength,
  input  logic                 inFifoEmpty,
  input  logic                 inFifoDone,
  input  logic                 inFifoData,
  input  logic                 inChipTick,
  output logic                 outFifoReadEnable,
  output logic                 outChip,
  output logic                 outChipValid,
  output logic                 outBusy,
  output logic                 outFrameDone,
  output logic                 outUnderrun,
  output logic                 outError
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] SYM0 = 32'b11011001110000110101001000101110;

  typedef enum logic [2:0] {
    IDLE,
    WAITDATA,
    REQ,
    GAP,
    STORE
  } fetch_t;

  fetch_t               state;
  fetch_t               next;
  logic [TW-1:0]        tcnt;
  logic [2:0]           bitcnt;
  logic [3:0]           shreg;
  logic [3:0]           buf_sym;
  logic                 buf_valid;
  logic [LEN_WIDTH-1:0] fetch_rem;
  logic [LEN_WIDTH-1:0] sym_rem;
  logic [31:0]          chips;
  logic [4:0]           idx;
  logic                 loaded;
  logic                 start_ok;
  logic                 go;
  logic                 timeout;
  logic                 last_chip;
  logic                 load;

  // Bit i of the result is chip c_i, so chips go out LSB first.
  function automatic logic [31:0] chip_seq(input logic [3:0] s);
    logic [5:0]  sh;
    logic [31:0] v;
    logic [31:0] r;
    sh = {1'b0, s[2:0], 2'b00};
    v  = (SYM0 >> sh) | (SYM0 << (6'd32 - sh));
    if (s[3]) v = v ^ 32'h5555_5555;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  assign start_ok  = inStart && !outBusy;
  assign go        = start_ok && (inLength != '0);
  assign timeout   = (state == REQ) && !inFifoDone &&
                     (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign last_chip = inChipTick && loaded && (idx == 5'd31);
  assign load      = buf_valid && (!loaded || last_chip);

  assign outFifoReadEnable = (state == REQ);

  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) state <= IDLE;
    else          state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:     if (go) next = WAITDATA;
      WAITDATA: if (!inFifoEmpty && !buf_valid) next = REQ;
      REQ: begin
        if (inFifoDone)   next = GAP;
        else if (timeout) next = IDLE;
      end
      GAP:      next = (bitcnt < 3'd4) ? REQ : STORE;
      STORE:    next = (fetch_rem == LEN_WIDTH'(1)) ? IDLE : WAITDATA;
      default:  next = IDLE;
    endcase
  end

  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      tcnt      <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      buf_sym   <= '0;
      buf_valid <= 1'b0;
      fetch_rem <= '0;
    end else begin
      tcnt <= (state == REQ) ? tcnt + TW'(1) : '0;
      if (state == WAITDATA) bitcnt <= '0;
      if (state == REQ && inFifoDone) begin
        shreg[bitcnt[1:0]] <= inFifoData;
        bitcnt             <= bitcnt + 3'd1;
      end
      if (go) fetch_rem <= inLength;
      if (state == STORE) begin
        buf_sym   <= shreg;
        fetch_rem <= fetch_rem - LEN_WIDTH'(1);
      end
      if (timeout)             buf_valid <= 1'b0;
      else if (state == STORE) buf_valid <= 1'b1;
      else if (load)           buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      chips        <= '0;
      idx          <= '0;
      loaded       <= 1'b0;
      sym_rem      <= '0;
      outChip      <= 1'b0;
      outChipValid <= 1'b0;
      outBusy      <= 1'b0;
      outFrameDone <= 1'b0;
      outUnderrun  <= 1'b0;
      outError     <= 1'b0;
    end else begin
      outChipValid <= 1'b0;
      outFrameDone <= 1'b0;
      if (timeout) begin
        loaded   <= 1'b0;
        idx      <= '0;
        sym_rem  <= '0;
        outBusy  <= 1'b0;
        outError <= 1'b1;
      end else begin
        if (start_ok) begin
          outUnderrun <= 1'b0;
          outError    <= 1'b0;
          if (inLength != '0) begin
            outBusy <= 1'b1;
            sym_rem <= inLength;
          end
        end
        if (outFrameDone) outBusy <= 1'b0;
        if (inChipTick && loaded) begin
          outChip      <= chips[0];
          chips        <= chips >> 1;
          idx          <= idx + 5'd1;
          outChipValid <= 1'b1;
          if (idx == 5'd31) begin
            sym_rem <= sym_rem - LEN_WIDTH'(1);
            loaded  <= 1'b0;
            if (sym_rem == LEN_WIDTH'(1)) outFrameDone <= 1'b1;
          end
        end else if (inChipTick && sym_rem != '0) begin
          outUnderrun <= 1'b1;
        end
        // A finished symbol hands over to the buffered one on the same edge.
        if (load) begin
          chips  <= chip_seq(buf_sym);
          idx    <= '0;
          loaded <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_chip_spreader.sv
// Testbench for chip_spreader: FIFO model, chip-sequence reference model,
// table-driven frames, randomized frames and timeout/underrun/reset sequences.
module tb_chip_spreader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] len_in;
  logic       fifo_empty;
  logic       fifo_done;
  logic       fifo_data;
  logic       chip_tick;
  logic       rd_en;
  logic       chip;
  logic       chip_valid;
  logic       busy;
  logic       frame_done;
  logic       underrun;
  logic       error;

  chip_spreader dut (
    .inClock          (clk),
    .inReset          (rst_n),
    .inStart          (start),
    .inLength         (len_in),
    .inFifoEmpty      (fifo_empty),
    .inFifoDone       (fifo_done),
    .inFifoData       (fifo_data),
    .inChipTick       (chip_tick),
    .outFifoReadEnable(rd_en),
    .outChip          (chip),
    .outChipValid     (chip_valid),
    .outBusy          (busy),
    .outFrameDone     (frame_done),
    .outUnderrun      (underrun),
    .outError         (error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference chip model: rotate the symbol-0 string, invert odd chips for 8..15
  string S0 = "11011001110000110101001000101110";

  function automatic logic model_chip(input int sym, input int i);
    int   k;
    logic b;
    k = (i - 4 * (sym % 8) + 64) % 32;
    b = (S0[k] == 8'h31);
    if (sym >= 8 && (i % 2) == 1) b = !b;
    return b;
  endfunction

  // FIFO model
  logic [3:0] mem [64];
  int wrptr = 0;
  int rdptr = 0;
  int bitpos = 0;
  int pend = -1;
  int reads = 0;
  int fifo_lat = 0;
  int respond = 1;
  int hold_empty = 0;
  int spur_req = 0;
  int spur_ack = 0;
  logic prev_rd = 1'b0;

  initial begin
    fifo_done  = 1'b0;
    fifo_data  = 1'b0;
    fifo_empty = 1'b1;
    forever begin
      @(negedge clk);
      fifo_done = 1'b0;
      fifo_data = 1'b0;
      if (!rst_n) begin
        pend   = -1;
        bitpos = 0;
      end else if (spur_req != spur_ack) begin
        fifo_done = 1'b1;
        fifo_data = 1'b1;
        spur_ack  = spur_req;
      end else begin
        if (rd_en && !prev_rd) begin
          reads++;
          if (respond != 0 && rdptr != wrptr) pend = fifo_lat;
        end
        if (pend == 0) begin
          fifo_done = 1'b1;
          fifo_data = mem[rdptr % 64][bitpos];
          bitpos++;
          if (bitpos == 4) begin
            bitpos = 0;
            rdptr++;
          end
          pend = -1;
        end else if (pend > 0) begin
          pend--;
        end
      end
      prev_rd    = rd_en;
      fifo_empty = (hold_empty != 0) || (rdptr == wrptr);
    end
  end

  // Chip tick generator
  int tick_per = 0;
  initial begin
    int cnt;
    cnt = 0;
    chip_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_per == 0) begin
        chip_tick = 1'b0;
        cnt = 0;
      end else if (cnt == 0) begin
        chip_tick = 1'b1;
        cnt = tick_per - 1;
      end else begin
        chip_tick = 1'b0;
        cnt--;
      end
    end
  end

  // Output monitor
  int   cyc = 0;
  logic got [$];
  int   fd_n = 0;
  int   fd_pos = -1;
  int   fd_cyc = -10;
  int   fall_cyc = -10;
  int   run = 0;
  int   last_run = 0;

  initial forever @(posedge clk) cyc++;

  initial begin
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (chip_valid) got.push_back(chip);
      if (frame_done) begin
        fd_n++;
        fd_pos = got.size();
        fd_cyc = cyc;
      end
      if (prev_busy && !busy) fall_cyc = cyc;
      if (rd_en) run++;
      else if (run > 0) begin
        last_run = run;
        run = 0;
      end
      prev_busy = busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic push_words(input int n, input logic [3:0] w0,
                            input logic [3:0] w1, input logic [3:0] w2,
                            input logic [3:0] w3);
    logic [3:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int k = 0; k < n; k++) begin
      mem[wrptr % 64] = w[k];
      wrptr++;
    end
  endtask

  task automatic pulse_start(input int n);
    @(negedge clk);
    start  = 1'b1;
    len_in = 8'(n);
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".bound"}, int'(n < limit), 1);
  endtask

  task automatic cmp_stream(input string tag, input int base,
                            input int n, input logic [3:0] w0,
                            input logic [3:0] w1, input logic [3:0] w2,
                            input logic [3:0] w3);
    logic [3:0] w [4];
    int mism;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    mism = 0;
    for (int s = 0; s < n; s++)
      for (int i = 0; i < 32; i++) begin
        int p;
        p = base + 32 * s + i;
        if (p >= got.size() || got[p] !== model_chip(int'(w[s]), i)) mism++;
      end
    chk({tag, ".nchips"}, got.size() - base, 32 * n);
    chk({tag, ".chip_mism"}, mism, 0);
  endtask

  task automatic run_frame(input string tag, input int n,
                           input logic [3:0] w0, input logic [3:0] w1,
                           input logic [3:0] w2, input logic [3:0] w3,
                           input int per, input int dly, input int lat,
                           input int exp_ur);
    int base, fd0, rd0;
    base = got.size();
    fd0  = fd_n;
    rd0  = reads;
    fifo_lat = lat;
    tick_per = 0;
    push_words(n, w0, w1, w2, w3);
    pulse_start(n);
    chk({tag, ".busy_on"}, int'(busy), int'(n != 0));
    repeat (dly) @(negedge clk);
    tick_per = per;
    wait_idle(tag, 4000);
    repeat (4) @(negedge clk);
    tick_per = 0;
    cmp_stream(tag, base, n, w0, w1, w2, w3);
    chk({tag, ".frame_done"}, fd_n - fd0, int'(n != 0));
    if (fd_n - fd0 == 1) begin
      chk({tag, ".fd_last_chip"}, fd_pos - base, 32 * n);
      chk({tag, ".busy_fall"}, fall_cyc - fd_cyc, 1);
    end
    chk({tag, ".underrun"}, int'(underrun), exp_ur);
    chk({tag, ".error"}, int'(error), 0);
    chk({tag, ".reads"}, reads - rd0, 4 * n);
  endtask

  typedef struct {
    string      tag;
    int         n;
    logic [3:0] w0, w1, w2, w3;
    int         per;
    int         dly;
    int         exp_ur;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int base, fd0, rd0;
    logic [3:0] r [4];

    vecs[0] = '{"sym0_t4",    1, 4'h0, 4'h0, 4'h0, 4'h0, 4, 40, 0};
    vecs[1] = '{"sym1_9_t2",  2, 4'h1, 4'h9, 4'h0, 4'h0, 2, 40, 0};
    vecs[2] = '{"three_t3",   3, 4'h5, 4'hC, 4'hF, 4'h0, 3, 40, 0};
    vecs[3] = '{"len0",       0, 4'h0, 4'h0, 4'h0, 4'h0, 2, 40, 0};
    vecs[4] = '{"early_tick", 1, 4'h7, 4'h0, 4'h0, 4'h0, 2, 0,  1};

    rst_n  = 1'b0;
    start  = 1'b0;
    len_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        int'({rd_en, chip, chip_valid, busy, frame_done, underrun, error}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++)
      run_frame(vecs[v].tag, vecs[v].n, vecs[v].w0, vecs[v].w1,
                vecs[v].w2, vecs[v].w3, vecs[v].per, vecs[v].dly, 0,
                vecs[v].exp_ur);

    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 4; k++) r[k] = 4'($urandom_range(0, 15));
      run_frame($sformatf("rand%0d", t), int'($urandom_range(1, 4)),
                r[0], r[1], r[2], r[3], int'($urandom_range(2, 4)), 60,
                int'($urandom_range(0, 3)), 0);
    end

    // FIFO held empty: ticks underrun, then the symbol goes out normally
    base = got.size();
    fd0  = fd_n;
    rd0  = reads;
    hold_empty = 1;
    push_words(1, 4'h2, 4'h0, 4'h0, 4'h0);
    pulse_start(1);
    tick_per = 2;
    repeat (100) @(negedge clk);
    chk("empty.underrun", int'(underrun), 1);
    chk("empty.no_chips", got.size() - base, 0);
    chk("empty.no_reads", reads - rd0, 0);
    hold_empty = 0;
    wait_idle("empty", 2000);
    repeat (4) @(negedge clk);
    tick_per = 0;
    cmp_stream("empty", base, 1, 4'h2, 4'h0, 4'h0, 4'h0);
    chk("empty.frame_done", fd_n - fd0, 1);
    chk("empty.underrun_sticky", int'(underrun), 1);

    // Read timeout
    base = got.size();
    fd0  = fd_n;
    respond = 0;
    push_words(1, 4'h4, 4'h0, 4'h0, 4'h0);
    pulse_start(1);
    wait_idle("timeout", 300);
    repeat (3) @(negedge clk);
    chk("timeout.rd_high_cycles", last_run, 15);
    chk("timeout.rd_en_low", int'(rd_en), 0);
    chk("timeout.error", int'(error), 1);
    chk("timeout.busy", int'(busy), 0);
    chk("timeout.no_frame_done", fd_n - fd0, 0);
    chk("timeout.no_chips", got.size() - base, 0);
    wrptr = rdptr;
    respond = 1;
    pulse_start(0);
    chk("timeout.error_cleared", int'(error), 0);
    chk("timeout.len0_busy", int'(busy), 0);

    // Reset in the middle of symbol 2 of a 4-symbol frame
    base = got.size();
    fifo_lat = 0;
    push_words(4, 4'h4, 4'h5, 4'h6, 4'h7);
    pulse_start(4);
    repeat (40) @(negedge clk);
    tick_per = 2;
    begin
      int n;
      n = 0;
      while (got.size() - base < 42 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      chk("midreset.reach_chip", int'(n < 2000), 1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset.outputs",
        int'({rd_en, chip_valid, busy, frame_done, underrun, error}), 0);
    chk("midreset.chip", int'(chip), 0);
    tick_per = 0;
    @(negedge clk);
    wrptr = rdptr;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    spur_req++;
    repeat (5) @(negedge clk);
    chk("midreset.idle_after", int'({rd_en, busy}), 0);
    run_frame("after_reset", 1, 4'h3, 4'h0, 4'h0, 4'h0, 2, 40, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
